// File: rtl/tron_bike_engine.sv
// Two-player TRON core driving a 160x120 vga_adapter: screen clear, head placement, ticked movement,
// occupancy-map collision checking and winner report. Define WRAP_EN to make screen edges wrap around.
module tron_bike_engine #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter logic [2:0]  P1_COL   = 3'b100,
  parameter logic [2:0]  P2_COL   = 3'b001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [1:0] p1_dir,
  input  logic       p1_dir_vld,
  input  logic [1:0] p2_dir,
  input  logic       p2_dir_vld,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       game_over,
  output logic [1:0] winner
);

`ifdef WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_CLEAR, S_HEAD1, S_HEAD2, S_IDLE, S_RUN, S_NEXT, S_RD1,
    S_RD2, S_CHECK, S_DRAW1, S_DRAW2, S_RESOLVE, S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  cx_q, p1x_q, p2x_q, n1x_q, n2x_q, x_q, x_d;
  logic [6:0]  cy_q, p1y_q, p2y_q, n1y_q, n2y_q, y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d, over_q, over_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  d1_q, d2_q, pd1_q, pd2_q, pd1_d, pd2_d, eff1, eff2;
  logic        pv1_q, pv2_q, pv1_d, pv2_d, acc1, acc2, in_play;
  logic        off1_q, off2_q, hit1_q, c1_q, c2_q, same, rd_q;
  logic        mem_we, mem_wd;
  logic [14:0] mem_wa, rd_addr;
  logic        occ_mem [0:19199];

  function automatic logic [14:0] addr_of(input logic [7:0] px, input logic [6:0] py);
    return 15'({py, 7'b0}) + 15'({py, 5'b0}) + 15'(px);
  endfunction

  // Returns {off_screen, next_x, next_y}; an off-screen bike keeps its current cell.
  function automatic logic [15:0] step(input logic [7:0] px, input logic [6:0] py, input logic [1:0] d);
    logic       off;
    logic [7:0] nx;
    logic [6:0] ny;
    off = 1'b0;
    nx  = px;
    ny  = py;
    case (d)
      2'd0: if (py == 7'd0) begin if (WRAP) ny = 7'd119; else off = 1'b1; end else ny = py - 7'd1;
      2'd1: if (px == 8'd159) begin if (WRAP) nx = 8'd0; else off = 1'b1; end else nx = px + 8'd1;
      2'd2: if (py == 7'd119) begin if (WRAP) ny = 7'd0; else off = 1'b1; end else ny = py + 7'd1;
      default: if (px == 8'd0) begin if (WRAP) nx = 8'd159; else off = 1'b1; end else nx = px - 8'd1;
    endcase
    return {off, nx, ny};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (cx_q == 8'd159 && cy_q == 7'd119) state_d = S_HEAD1;
      S_HEAD1:   state_d = S_HEAD2;
      S_HEAD2:   state_d = S_IDLE;
      S_IDLE:    if (go) state_d = S_RUN;
      S_RUN:     if (cnt_q == TICK_DIV - 1) state_d = S_NEXT;
      S_NEXT:    state_d = S_RD1;
      S_RD1:     state_d = S_RD2;
      S_RD2:     state_d = S_CHECK;
      S_CHECK:   state_d = S_DRAW1;
      S_DRAW1:   state_d = S_DRAW2;
      S_DRAW2:   state_d = S_RESOLVE;
      S_RESOLVE: state_d = (c1_q || c2_q) ? S_OVER : S_RUN;
      default:   state_d = S_OVER;
    endcase
  end

  always_comb begin
    plot_d = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    over_d = 1'b0;
    win_d  = '0;
    case (state_q)
      S_CLEAR: begin plot_d = 1'b1; x_d = cx_q;   y_d = cy_q;  col_d = '0;     end
      S_HEAD1: begin plot_d = 1'b1; x_d = 8'd40;  y_d = 7'd60; col_d = P1_COL; end
      S_HEAD2: begin plot_d = 1'b1; x_d = 8'd119; y_d = 7'd60; col_d = P2_COL; end
      S_DRAW1: begin plot_d = !c1_q; x_d = n1x_q; y_d = n1y_q; col_d = P1_COL; end
      S_DRAW2: begin plot_d = !c2_q; x_d = n2x_q; y_d = n2y_q; col_d = P2_COL; end
      S_OVER:  begin over_d = 1'b1; win_d = {c1_q, c2_q}; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0; y_q <= '0; col_q <= '0; plot_q <= 1'b0; over_q <= 1'b0; win_q <= '0;
    end else begin
      x_q <= x_d; y_q <= y_d; col_q <= col_d; plot_q <= plot_d; over_q <= over_d; win_q <= win_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = col_q;
  assign plot      = plot_q;
  assign game_over = over_q;
  assign winner    = win_q;

  // A strobe arriving on the tick cycle is judged against the heading being applied in that cycle.
  assign in_play = !(state_q inside {S_CLEAR, S_HEAD1, S_HEAD2});
  assign eff1    = (state_q == S_NEXT && pv1_q) ? pd1_q : d1_q;
  assign eff2    = (state_q == S_NEXT && pv2_q) ? pd2_q : d2_q;
  assign acc1    = in_play && p1_dir_vld && (p1_dir != (eff1 ^ 2'b10));
  assign acc2    = in_play && p2_dir_vld && (p2_dir != (eff2 ^ 2'b10));
  assign pv1_d   = !in_play ? 1'b0 : acc1 ? 1'b1 : (state_q == S_NEXT) ? 1'b0 : pv1_q;
  assign pv2_d   = !in_play ? 1'b0 : acc2 ? 1'b1 : (state_q == S_NEXT) ? 1'b0 : pv2_q;
  assign pd1_d   = acc1 ? p1_dir : pd1_q;
  assign pd2_d   = acc2 ? p2_dir : pd2_q;
  assign cnt_d   = (state_q == S_RUN && cnt_q != TICK_DIV - 1) ? cnt_q + 32'd1 : '0;
  assign same    = (n1x_q == n2x_q) && (n1y_q == n2y_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0; cx_q <= '0; cy_q <= '0;
      pv1_q <= 1'b0; pv2_q <= 1'b0; pd1_q <= '0; pd2_q <= '0;
      d1_q <= 2'd1; d2_q <= 2'd3;
      p1x_q <= '0; p1y_q <= '0; p2x_q <= '0; p2y_q <= '0;
      n1x_q <= '0; n1y_q <= '0; n2x_q <= '0; n2y_q <= '0;
      off1_q <= 1'b0; off2_q <= 1'b0; hit1_q <= 1'b0; c1_q <= 1'b0; c2_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pv1_q <= pv1_d; pv2_q <= pv2_d; pd1_q <= pd1_d; pd2_q <= pd2_d;
      case (state_q)
        S_CLEAR: begin
          if (cx_q == 8'd159) begin
            cx_q <= '0;
            cy_q <= (cy_q == 7'd119) ? 7'd0 : cy_q + 7'd1;
          end else begin
            cx_q <= cx_q + 8'd1;
          end
        end
        S_HEAD1: begin p1x_q <= 8'd40;  p1y_q <= 7'd60; d1_q <= 2'd1; c1_q <= 1'b0; end
        S_HEAD2: begin p2x_q <= 8'd119; p2y_q <= 7'd60; d2_q <= 2'd3; c2_q <= 1'b0; end
        S_NEXT: begin
          d1_q <= eff1;
          d2_q <= eff2;
          {off1_q, n1x_q, n1y_q} <= step(p1x_q, p1y_q, eff1);
          {off2_q, n2x_q, n2y_q} <= step(p2x_q, p2y_q, eff2);
        end
        S_RD2:   hit1_q <= rd_q;
        S_CHECK: begin
          c1_q <= off1_q | hit1_q | same;
          c2_q <= off2_q | rd_q | same;
        end
        S_DRAW1: if (!c1_q) begin p1x_q <= n1x_q; p1y_q <= n1y_q; end
        S_DRAW2: if (!c2_q) begin p2x_q <= n2x_q; p2y_q <= n2y_q; end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_of(cx_q, cy_q);
    mem_wd = 1'b0;
    case (state_q)
      S_CLEAR: mem_we = 1'b1;
      S_HEAD1: begin mem_we = 1'b1; mem_wa = addr_of(8'd40, 7'd60);  mem_wd = 1'b1; end
      S_HEAD2: begin mem_we = 1'b1; mem_wa = addr_of(8'd119, 7'd60); mem_wd = 1'b1; end
      S_DRAW1: begin mem_we = !c1_q; mem_wa = addr_of(n1x_q, n1y_q); mem_wd = 1'b1; end
      S_DRAW2: begin mem_we = !c2_q; mem_wa = addr_of(n2x_q, n2y_q); mem_wd = 1'b1; end
      default: ;
    endcase
  end

  assign rd_addr = (state_q == S_RD2) ? addr_of(n2x_q, n2y_q) : addr_of(n1x_q, n1y_q);

  always_ff @(posedge clock) begin
    if (mem_we) occ_mem[mem_wa] <= mem_wd;
    rd_q <= occ_mem[rd_addr];
  end

endmodule

// File: tb/tb_tron_bike_engine.sv
// Bench for tron_bike_engine: grid-level game model driven by directed scenarios and random steering.
module tb_tron_bike_engine;
  localparam int unsigned TD = 8;
  localparam logic [2:0] C1 = 3'b100;
  localparam logic [2:0] C2 = 3'b001;

  logic       clock = 1'b0, reset = 1'b1, go = 1'b0;
  logic [1:0] p1_dir = '0, p2_dir = '0;
  logic       p1_dir_vld = 1'b0, p2_dir_vld = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, game_over;
  logic [1:0] winner;

  always #5 clock = ~clock;

  tron_bike_engine #(.TICK_DIV(TD), .P1_COL(C1), .P2_COL(C2)) dut (
    .clock(clock), .reset(reset), .go(go),
    .p1_dir(p1_dir), .p1_dir_vld(p1_dir_vld), .p2_dir(p2_dir), .p2_dir_vld(p2_dir_vld),
    .x(x), .y(y), .colour(colour), .plot(plot), .game_over(game_over), .winner(winner)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [17:0] obs_q[$];
  always @(negedge clock) if (plot === 1'b1) obs_q.push_back({x, y, colour});

  // Game model: a 160x120 grid of occupied cells plus each bike's cell, heading and pending turn.
  bit          grid [0:159][0:119];
  int          mx[2], my[2], mh[2], mpd[2];
  bit          mpv[2];
  bit          m_over;
  int          m_win;
  logic [17:0] exp_q[$];
  int          DX[4] = '{0, 1, 0, -1};
  int          DY[4] = '{-1, 0, 1, 0};

  function automatic void m_init();
    for (int i = 0; i < 160; i++) for (int j = 0; j < 120; j++) grid[i][j] = 1'b0;
    mx[0] = 40;  my[0] = 60; mh[0] = 1;
    mx[1] = 119; my[1] = 60; mh[1] = 3;
    grid[40][60] = 1'b1; grid[119][60] = 1'b1;
    mpv[0] = 1'b0; mpv[1] = 1'b0; m_over = 1'b0; m_win = 0;
    exp_q.delete();
  endfunction

  function automatic void m_strobe(input int p, input int d);
    if (d != (mh[p] + 2) % 4) begin mpd[p] = d; mpv[p] = 1'b1; end
  endfunction

  function automatic void m_tick();
    int nx[2], ny[2];
    bit off[2], cr[2];
    for (int p = 0; p < 2; p++) begin
      if (mpv[p]) mh[p] = mpd[p];
      mpv[p] = 1'b0;
      nx[p] = mx[p] + DX[mh[p]];
      ny[p] = my[p] + DY[mh[p]];
`ifdef WRAP_EN
      nx[p] = (nx[p] + 160) % 160;
      ny[p] = (ny[p] + 120) % 120;
      off[p] = 1'b0;
`else
      off[p] = (nx[p] < 0) || (nx[p] > 159) || (ny[p] < 0) || (ny[p] > 119);
`endif
    end
    for (int p = 0; p < 2; p++)
      cr[p] = off[p] || grid[off[p] ? 0 : nx[p]][off[p] ? 0 : ny[p]] || (nx[0] == nx[1] && ny[0] == ny[1]);
    for (int p = 0; p < 2; p++)
      if (!cr[p]) begin
        grid[nx[p]][ny[p]] = 1'b1;
        mx[p] = nx[p]; my[p] = ny[p];
        exp_q.push_back({8'(nx[p]), 7'(ny[p]), (p == 0) ? C1 : C2});
      end
    if (cr[0] || cr[1]) m_over = 1'b1;
    m_win = (cr[0] ? 2 : 0) + (cr[1] ? 1 : 0);
  endfunction

  task automatic strobe(input bit v1, input logic [1:0] d1, input bit v2, input logic [1:0] d2);
    @(negedge clock);
    p1_dir_vld = v1; p1_dir = d1; p2_dir_vld = v2; p2_dir = d2;
    if (v1) m_strobe(0, int'(d1));
    if (v2) m_strobe(1, int'(d2));
    @(negedge clock);
    p1_dir_vld = 1'b0; p2_dir_vld = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
  endtask

  task automatic run_round(input string tag);
    int n;
    logic [17:0] e, o;
    m_tick();
    n = exp_q.size();
    for (int i = 0; i < 60 && !(obs_q.size() >= n && (!m_over || game_over === 1'b1)); i++)
      @(negedge clock);
    if (m_over) repeat (20) @(negedge clock);
    check_eq({tag, "_nplot"}, obs_q.size(), n);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({tag, "_x"}, int'(o[17:10]), int'(e[17:10]));
      check_eq({tag, "_y"}, int'(o[9:3]), int'(e[9:3]));
      check_eq({tag, "_col"}, int'(o[2:0]), int'(e[2:0]));
    end
    exp_q.delete();
    obs_q.delete();
    check_eq({tag, "_over"}, int'(game_over), int'(m_over));
    check_eq({tag, "_win"}, int'(winner), m_win);
  endtask

  task automatic start_game(input bit full);
    int errs;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    if (full) begin
      check_eq("rst_x", int'(x), 0);
      check_eq("rst_y", int'(y), 0);
      check_eq("rst_col", int'(colour), 0);
      check_eq("rst_plot", int'(plot), 0);
      check_eq("rst_over", int'(game_over), 0);
      check_eq("rst_win", int'(winner), 0);
    end
    reset = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 19400 && obs_q.size() < 19202; i++) @(negedge clock);
    repeat (10) @(negedge clock);
    check_eq("clr_count", obs_q.size(), 19202);
    if (full) begin
      errs = 0;
      for (int i = 0; i < 19200 && i < obs_q.size(); i++)
        if (obs_q[i] !== {8'(i % 160), 7'(i / 160), 3'b000}) errs++;
      check_eq("clr_raster", errs, 0);
      if (obs_q.size() >= 19200) begin
        check_eq("clr_first", int'(obs_q[0]), int'({8'd0, 7'd0, 3'b000}));
        check_eq("clr_last", int'(obs_q[19199]), int'({8'd159, 7'd119, 3'b000}));
      end
    end
    if (obs_q.size() >= 19202) begin
      check_eq("head1", int'(obs_q[19200]), int'({8'd40, 7'd60, C1}));
      check_eq("head2", int'(obs_q[19201]), int'({8'd119, 7'd60, C2}));
    end
    obs_q.delete();
    m_init();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k;
    bit v1, v2;
    logic [1:0] d1, d2;

    // Game 1: clear, straight run with discarded reversal requests, ends head-on.
    start_game(1'b1);
    r = 0;
    while (!m_over && r < 100) begin
      if ($urandom_range(0, 1) == 1) strobe(1'b1, 2'd3, 1'($urandom_range(0, 1)), 2'd1);
      if (r == 0) pulse_go();
      run_round("straight");
      r++;
    end
    check_eq("headon_win", int'(winner), 3);

    // Game 2: P1 turns up (P2 reversal ignored), then loops back into its start cell.
    start_game(1'b0);
    strobe(1'b1, 2'd0, 1'b1, 2'd1);
    pulse_go();
    run_round("turn");
    strobe(1'b1, 2'd3, 1'b0, 2'd0);
    run_round("loop_l");
    strobe(1'b1, 2'd2, 1'b0, 2'd0);
    run_round("loop_d");
    strobe(1'b1, 2'd1, 1'b0, 2'd0);
    run_round("selfhit");
    check_eq("selfhit_win", int'(winner), 2);

    // Game 3: P1 heads straight up to the top edge.
    start_game(1'b0);
    strobe(1'b1, 2'd0, 1'b0, 2'd0);
    pulse_go();
    r = 0;
    while (!m_over && r < 200) begin
      run_round("edge");
      r++;
    end
`ifndef WRAP_EN
    check_eq("edge_win", int'(winner), 2);
`endif

    // Game 4: random steering, then reset while the game is running.
    start_game(1'b0);
    k = $urandom_range(3, 8);
    r = 0;
    while (!m_over && r < k) begin
      v1 = ($urandom_range(0, 2) == 0);
      v2 = ($urandom_range(0, 2) == 0);
      d1 = 2'($urandom_range(0, 3));
      d2 = 2'($urandom_range(0, 3));
      strobe(v1, d1, v2, d2);
      if ($urandom_range(0, 3) == 0) strobe(1'b1, 2'($urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)));
      if (r == 0) pulse_go();
      run_round("rand");
      r++;
    end
    repeat ($urandom_range(1, 4)) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_plot", int'(plot), 0);
    check_eq("mid_rst_over", int'(game_over), 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reclear_plot", int'(plot), 1);
    check_eq("reclear_xy", int'({x, y}), 0);
    check_eq("reclear_col", int'(colour), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
